// File: rtl/aes_pkg.sv
// Shared AES arithmetic, state layout and FSM encoding for the AES-128 datapaths.
// Byte 0 sits in bits [127:120]; the state is column-major, indexed [col][row].
package aes_pkg;

  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned BYTE_W  = 8;

  typedef logic [0:3][0:3][BYTE_W-1:0] state_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_KEXP,
    ST_ROUND,
    ST_DONE
  } dec_fsm_e;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] acc;
    sq  = x;
    acc = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      acc = gf_mul(acc, sq);
    end
    return acc;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int unsigned n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ rotl8(i, 1) ^ rotl8(i, 2) ^ rotl8(i, 3) ^ rotl8(i, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic state_t to_state(input logic [BLOCK_W-1:0] v);
    return state_t'(v);
  endfunction

  function automatic logic [BLOCK_W-1:0] from_state(input state_t s);
    return BLOCK_W'(s);
  endfunction

endpackage

// File: rtl/aes_inv_round.sv
// One combinational AES inverse round: InvShiftRows, InvSubBytes, AddRoundKey,
// then InvMixColumns unless last_round is set.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [BLOCK_W-1:0] round_key,
  input  logic               last_round,
  output logic [BLOCK_W-1:0] result_c
);

  state_t s_in;
  state_t key_st;
  state_t sub_st;
  state_t mix_st;

  assign s_in   = to_state(state);
  assign key_st = to_state(round_key);

  // row r is rotated right by r columns before the inverse S-box
  always_comb begin
    sub_st = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sub_st[c][r] = inv_sbox(s_in[2'(c - r)][r]) ^ key_st[c][r];
      end
    end
  end

  always_comb begin
    mix_st = '0;
    for (int c = 0; c < 4; c++) begin
      mix_st[c][0] = gf_mul(sub_st[c][0], 8'h0e) ^ gf_mul(sub_st[c][1], 8'h0b) ^
                     gf_mul(sub_st[c][2], 8'h0d) ^ gf_mul(sub_st[c][3], 8'h09);
      mix_st[c][1] = gf_mul(sub_st[c][0], 8'h09) ^ gf_mul(sub_st[c][1], 8'h0e) ^
                     gf_mul(sub_st[c][2], 8'h0b) ^ gf_mul(sub_st[c][3], 8'h0d);
      mix_st[c][2] = gf_mul(sub_st[c][0], 8'h0d) ^ gf_mul(sub_st[c][1], 8'h09) ^
                     gf_mul(sub_st[c][2], 8'h0e) ^ gf_mul(sub_st[c][3], 8'h0b);
      mix_st[c][3] = gf_mul(sub_st[c][0], 8'h0b) ^ gf_mul(sub_st[c][1], 8'h0d) ^
                     gf_mul(sub_st[c][2], 8'h09) ^ gf_mul(sub_st[c][3], 8'h0e);
    end
  end

  assign result_c = from_state(last_round ? sub_st : mix_st);

endmodule

// File: rtl/aes128_decryption_core.sv
// Iterative AES-128 decryptor: walks the key schedule forward to rk10, then runs
// ten inverse rounds while stepping the schedule back one round key per clock.
module aes128_decryption_core
  import aes_pkg::*;
#(
  parameter int unsigned N  = 128,
  parameter int unsigned NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] decr_ciphertext_input,
  input  logic [N-1:0] secret_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] decr_plaintext_output
);

  localparam logic [3:0] LAST_RND = 4'(NR);

  dec_fsm_e     fsm, fsm_next;
  logic [N-1:0] state_reg, state_next;
  logic [N-1:0] key_reg, key_next;
  logic [3:0]   rnd, rnd_next;
  logic         in_ready_next;
  logic         out_valid_next;
  logic [N-1:0] fwd_key;
  logic [N-1:0] inv_key;
  logic [N-1:0] round_out;
  logic         last_round;

  function automatic logic [31:0] sub_rot_word(input logic [31:0] w, input logic [7:0] rc);
    return {sbox(w[23:16]) ^ rc, sbox(w[15:8]), sbox(w[7:0]), sbox(w[31:24])};
  endfunction

  // rk(i-1) -> rk(i)
  function automatic logic [N-1:0] fwd_key_step(input logic [N-1:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3;
    {w0, w1, w2, w3} = k;
    w0 = w0 ^ sub_rot_word(w3, rc);
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // rk(i) -> rk(i-1); undo the XOR chain before recovering word 0
  function automatic logic [N-1:0] inv_key_step(input logic [N-1:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    logic [31:0] w0, w1, w2, w3;
    {n0, n1, n2, n3} = k;
    w3 = n3 ^ n2;
    w2 = n2 ^ n1;
    w1 = n1 ^ n0;
    w0 = n0 ^ sub_rot_word(w3, rc);
    return {w0, w1, w2, w3};
  endfunction

  assign fwd_key    = fwd_key_step(key_reg, rcon(rnd));
  assign inv_key    = inv_key_step(key_reg, rcon(4'(4'd11 - rnd)));
  assign last_round = (rnd == LAST_RND);

  aes_inv_round u_inv_round (
    .state      (state_reg),
    .round_key  (inv_key),
    .last_round (last_round),
    .result_c   (round_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= ST_IDLE;
      state_reg <= '0;
      key_reg   <= '0;
      rnd       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      fsm       <= fsm_next;
      state_reg <= state_next;
      key_reg   <= key_next;
      rnd       <= rnd_next;
      in_ready  <= in_ready_next;
      out_valid <= out_valid_next;
    end
  end

  always_comb begin
    fsm_next   = fsm;
    state_next = state_reg;
    key_next   = key_reg;
    rnd_next   = rnd;
    case (fsm)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          state_next = decr_ciphertext_input;
          key_next   = secret_key;
          rnd_next   = 4'd1;
          fsm_next   = ST_KEXP;
        end
      end
      ST_KEXP: begin
        key_next = fwd_key;
        rnd_next = rnd + 4'd1;
        if (rnd == LAST_RND) begin
          state_next = state_reg ^ fwd_key;
          rnd_next   = 4'd1;
          fsm_next   = ST_ROUND;
        end
      end
      ST_ROUND: begin
        key_next   = inv_key;
        state_next = round_out;
        if (last_round) fsm_next = ST_DONE;
        else            rnd_next = rnd + 4'd1;
      end
      ST_DONE: begin
        if (out_ready) fsm_next = ST_IDLE;
      end
      default: fsm_next = ST_IDLE;
    endcase
    in_ready_next  = (fsm_next == ST_IDLE);
    out_valid_next = (fsm_next == ST_DONE);
  end

  assign decr_plaintext_output = state_reg;

endmodule

// File: doc/aes128_decryption_core.md
# aes128_decryption_core

Iterative AES-128 decryption engine, the inverse-direction counterpart of the team's AES-128 encryption datapath. It accepts one 128-bit ciphertext and 128-bit secret key through a valid/ready handshake. It expands the key forward to round key 10, then executes the 10 inverse rounds one per clock while stepping the key schedule backwards. The recovered plaintext is presented on a valid/ready output port. It sits beside the encryption block in the crypto subsystem and shares its byte/column ordering (bit 127 = byte 0, column-major state).

## Interface
- N, 128, block and key width; only 128 is supported
- NR, 10, number of AES rounds; fixed for AES-128
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  ciphertext/key offered
- in_ready  output  1  core idle and able to accept
- decr_ciphertext_input  input  N  ciphertext, sampled on accept
- secret_key  input  N  cipher key, sampled on accept
- out_valid  output  1  plaintext available
- out_ready  input  1  consumer accepts plaintext
- decr_plaintext_output  output  N  recovered plaintext

## Operation
- States:
  - IDLE: in_ready=1. An accept (in_valid & in_ready) loads state_reg←ciphertext, key_reg←secret_key, rnd←1, and moves to KEXP.
  - KEXP: key_reg←fwd_step(key_reg, rcon[rnd]), rnd++. When rnd=10, additionally state_reg←state_reg ^ fwd_step(...) (AddRoundKey with rk10), rnd←1, and move to ROUND.
  - ROUND (rnd = 1..10): k = inv_step(key_reg, rcon[11−rnd]) = rk(10−rnd); key_reg←k.
    - rnd 1..9: state_reg←InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state_reg)), k)).
    - rnd 10: same without InvMixColumns. Move to DONE.
  - DONE: out_valid=1. On out_ready go to IDLE.
- decr_plaintext_output = state_reg. It is stable and valid whenever out_valid=1.
- Input ports are ignored outside IDLE. Changes to decr_ciphertext_input or secret_key mid-operation have no effect.
- No pipelining: exactly one block is in flight.
- rcon and S-box arithmetic follow FIPS-197, GF(2^8) polynomial 0x11B.

## Timing
- Reset values: in_ready=0 while rst is asserted and 1 in IDLE after release; out_valid=0; decr_plaintext_output=0; internal key_reg=0, rnd=0.
- Accept in cycle T:
  - KEXP occupies cycles T+1..T+10.
  - ROUND occupies cycles T+11..T+20.
  - out_valid rises at T+21.
  - Latency is 21 cycles from accept to out_valid.
- Output handshake completes in the cycle where out_valid & out_ready are both 1. in_ready rises the next cycle.
- Back-to-back maximum throughput: one block per 22 cycles.
- out_ready held low: the core stays in DONE indefinitely with the output held, and in_ready stays 0.
- rst asserted in any state, including mid-ROUND: return to IDLE immediately. out_valid=0, and the partial result is discarded and never emitted.
- in_valid asserted while in_ready=0: no effect. No queuing occurs.

## Structure
- Shared package aes_pkg:
  - sbox and inv_sbox functions
  - xtime / gf_mul functions
  - rcon constant array
  - state typedef (4×4 bytes)
  - encode/decode of the N-bit vector to and from the state, shared with the encryption path
- Sub-module aes_inv_round (combinational): InvShiftRows → InvSubBytes → AddRoundKey → optional InvMixColumns, selected by a last_round input.
- Forward and inverse key-step logic lives in the core. Each consists of 4 S-box lookups plus XOR chains.
- The FSM, counter and registers stay in the core.

## Test plan
- FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f, ct 69c4e0d86a7b0430d8cdb78070b4c55a → pt 00112233445566778899aabbccddeeff, out_valid exactly 21 cycles after accept.
- FIPS-197 Appendix B: key 2b7e151628aed2a6abf7158809cf4f3c, ct 3925841d02dc09fbdc118597196a0b32 → pt 3243f6a8885a308d313198a2e0370734.
- Backpressure: hold out_ready=0 for 50 cycles after out_valid. The output stays stable, in_ready=0, and a second in_valid is ignored. Raise out_ready, then accept the next block; in_ready=1 the cycle after the output handshake.
- Reset mid-ROUND: assert rst at T+15. out_valid never rises, all outputs read 0, and in_ready=1 after release. A fresh C.1 run then decrypts correctly.
- Input perturbation: change decr_ciphertext_input and secret_key every cycle after accept. The result still equals the accepted block's plaintext.
- Round-trip: 1000 random key/plaintext pairs encrypted by the encryption block, then fed here. Every output equals the original plaintext.
